board_ctrl: RTL and testbench

Parametrised board-level control block for the FPGA shells around the shader core. It takes the PLL-lock-qualified reset and raw active-low buttons, and produces:
- a synchronised, stretched core reset;
- debounced button levels and press pulses;
- a wrap-around mode register;
- active-low status LEDs driven by a vsync heartbeat and a frame watchdog.

It replaces ad-hoc glue logic in board tops. All outputs come from registers.

---
 rtl/board_ctrl_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/board_ctrl.sv | 149 ++++++++++++++
 tb/tb_board_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_ctrl_pkg.sv
// Shared types, default parameters and helpers for the board control block.
package board_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    localparam int unsigned N_BTN_DEF            = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEF  = 250000;
    localparam int unsigned RST_STRETCH_DEF      = 1024;
    localparam int unsigned N_MODES_DEF          = 4;
    localparam int unsigned HEARTBEAT_FRAMES_DEF = 30;
    localparam int unsigned FRAME_TIMEOUT_DEF    = 1000000;

    function automatic int unsigned mode_width(input int unsigned n_modes);
        return (n_modes > 1) ? $clog2(n_modes) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, debounced level and press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q;
    logic             sample;

    assign sample = ~sync2_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/board_ctrl.sv
// Board glue: core reset stretcher, debounced buttons, mode register, heartbeat and frame watchdog LEDs.
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN            = N_BTN_DEF,
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned RST_STRETCH      = RST_STRETCH_DEF,
    parameter int unsigned N_MODES          = N_MODES_DEF,
    parameter int unsigned HEARTBEAT_FRAMES = HEARTBEAT_FRAMES_DEF,
    parameter int unsigned FRAME_TIMEOUT    = FRAME_TIMEOUT_DEF,
    localparam int unsigned MODE_W          = mode_width(N_MODES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  btn_n_i,
    input  logic              vsync_i,
    output logic              rst_core_n,
    output logic [N_BTN-1:0]  btn_level_o,
    output logic [N_BTN-1:0]  btn_press_o,
    output logic [MODE_W-1:0] mode_o,
    output logic              led_r_n,
    output logic              led_g_n
);

    localparam int unsigned ST_W = $clog2(RST_STRETCH + 1);
    localparam int unsigned FR_W = $clog2(HEARTBEAT_FRAMES + 1);
    localparam int unsigned WD_W = $clog2(FRAME_TIMEOUT + 1);

    if (N_BTN < 3) begin : g_bad_n_btn
        $error("board_ctrl: N_BTN must be at least 3");
    end

    logic [N_BTN-1:0] btn_level, btn_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_n_i (btn_n_i[i]),
            .level_o (btn_level[i]),
            .press_o (btn_press[i])
        );
    end

    logic unused_press;
    assign unused_press = ^btn_press;

    rst_state_t        state_q, state_d;
    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [FR_W-1:0]   frame_q, frame_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              vs1_q, vs2_q, vs_prev_q, vs_rise;
    logic              rst_core_q, led_r_q, led_g_q, led_g_d;

    assign vs_rise = vs2_q & ~vs_prev_q;

    // Reset sequencing: button 0 holds the core; release stretches before RUN.
    always_comb begin
        state_d  = state_q;
        st_cnt_d = '0;
        case (state_q)
            HOLD: begin
                if (!btn_level[0]) state_d = STRETCH;
            end
            STRETCH: begin
                if (btn_level[0]) begin
                    state_d = HOLD;
                end else if (st_cnt_q == ST_W'(RST_STRETCH - 1)) begin
                    state_d = RUN;
                end else begin
                    st_cnt_d = st_cnt_q + ST_W'(1);
                end
            end
            RUN: begin
                if (btn_level[0]) state_d = HOLD;
            end
            default: state_d = HOLD;
        endcase
    end

    // Mode up/down with wrap; simultaneous presses cancel.
    always_comb begin
        mode_d = mode_q;
        if (btn_press[1] && !btn_press[2]) begin
            mode_d = (mode_q == MODE_W'(N_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
        end else if (btn_press[2] && !btn_press[1]) begin
            mode_d = (mode_q == '0) ? MODE_W'(N_MODES - 1) : mode_q - MODE_W'(1);
        end
    end

    // Heartbeat and watchdog only run while the core is out of reset.
    always_comb begin
        frame_d = frame_q;
        led_g_d = led_g_q;
        wd_d    = wd_q;
        if (state_q != RUN) begin
            frame_d = '0;
            led_g_d = 1'b1;
            wd_d    = '0;
        end else if (vs_rise) begin
            wd_d = '0;
            if (frame_q == FR_W'(HEARTBEAT_FRAMES - 1)) begin
                frame_d = '0;
                led_g_d = ~led_g_q;
            end else begin
                frame_d = frame_q + FR_W'(1);
            end
        end else if (wd_q != WD_W'(FRAME_TIMEOUT)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            st_cnt_q   <= '0;
            mode_q     <= '0;
            frame_q    <= '0;
            wd_q       <= '0;
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            vs_prev_q  <= 1'b0;
            rst_core_q <= 1'b0;
            led_r_q    <= 1'b0;
            led_g_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            st_cnt_q   <= st_cnt_d;
            mode_q     <= mode_d;
            frame_q    <= frame_d;
            wd_q       <= wd_d;
            vs1_q      <= vsync_i;
            vs2_q      <= vs1_q;
            vs_prev_q  <= vs2_q;
            rst_core_q <= (state_q == RUN);
            led_r_q    <= (state_d == RUN) && (wd_d != WD_W'(FRAME_TIMEOUT));
            led_g_q    <= led_g_d;
        end
    end

    assign rst_core_n  = rst_core_q;
    assign btn_level_o = btn_level;
    assign btn_press_o = btn_press;
    assign mode_o      = mode_q;
    assign led_r_n     = led_r_q;
    assign led_g_n     = led_g_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl with small parameters; mode changes checked via a scoreboard queue.
module tb_board_ctrl;

    localparam int unsigned NB = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned RS = 8;
    localparam int unsigned NM = 3;
    localparam int unsigned HB = 2;
    localparam int unsigned FT = 20;
    localparam int unsigned MW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_n;
    logic          vsync;
    logic          rst_core_n;
    logic [NB-1:0] btn_level, btn_press;
    logic [MW-1:0] mode;
    logic          led_r_n, led_g_n;

    board_ctrl #(
        .N_BTN            (NB),
        .DEBOUNCE_CYCLES  (DB),
        .RST_STRETCH      (RS),
        .N_MODES          (NM),
        .HEARTBEAT_FRAMES (HB),
        .FRAME_TIMEOUT    (FT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_n_i     (btn_n),
        .vsync_i     (vsync),
        .rst_core_n  (rst_core_n),
        .btn_level_o (btn_level),
        .btn_press_o (btn_press),
        .mode_o      (mode),
        .led_r_n     (led_r_n),
        .led_g_n     (led_g_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int mode_exp[$];
    int mode_prev = 0;
    int press_cnt[NB];

    initial for (int i = 0; i < NB; i++) press_cnt[i] = 0;

    // Scoreboard: every mode change must match the next expected value.
    always @(negedge clk) begin
        if (!rst_n) begin
            mode_exp.delete();
            mode_prev = 0;
        end else begin
            for (int i = 0; i < NB; i++) if (btn_press[i]) press_cnt[i]++;
            if (int'(mode) != mode_prev) begin
                if (mode_exp.size() == 0) check("mode_unexpected", int'(mode), mode_prev);
                else check("mode_seq", int'(mode), mode_exp.pop_front());
                mode_prev = int'(mode);
            end
        end
    end

    function automatic int sig(input int sel);
        case (sel)
            0:       return int'(rst_core_n);
            1:       return int'(btn_level[0]);
            2:       return int'(btn_level[1]);
            3:       return int'(btn_level[2]);
            default: return int'(led_r_n);
        endcase
    endfunction

    // Counts rising edges until the selected output reaches val; returns limit on timeout.
    task automatic edges_until(input int sel, input int val, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sig(sel) != val && n < limit);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int idx);
        int n;
        @(negedge clk);
        btn_n[idx] = 1'b0;
        edges_until(1 + idx, 1, 30, n);
        check("press_latency", n, 6);
        @(negedge clk);
        btn_n[idx] = 1'b1;
        edges_until(1 + idx, 0, 30, n);
        check("release_latency", n, 6);
        tick(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rst_core"}, int'(rst_core_n), 0);
        check({tag, "_led_r"},    int'(led_r_n),    0);
        check({tag, "_led_g"},    int'(led_g_n),    1);
        check({tag, "_level"},    int'(btn_level),  0);
        check({tag, "_press"},    int'(btn_press),  0);
        check({tag, "_mode"},     int'(mode),       0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, m, led8, seen, ledr_min;

        rst_n = 1'b0;
        btn_n = '1;
        vsync = 1'b0;
        #12;
        check_reset_values("por");

        // Release: STRETCH on first edge, RUN after 8 stretch cycles, rst_core one edge later.
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        led8 = -1;
        while (!rst_core_n && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 8) led8 = int'(led_r_n);
        end
        check("rst_release_edges", n, 10);
        check("led_r_before_run", led8, 0);
        check("led_r_in_run", int'(led_r_n), 1);
        check("led_g_in_run", int'(led_g_n), 1);

        // 3-cycle glitch on btn1 must be filtered.
        @(negedge clk);
        btn_n[1] = 1'b0;
        tick(3);
        btn_n[1] = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (btn_level[1]) seen = 1;
        end
        check("glitch_filtered", seen, 0);

        mode_exp.push_back(1);
        press_btn(1);
        check("press1_pulses", press_cnt[1], 1);

        mode_exp.push_back(2);
        press_btn(1);
        mode_exp.push_back(0);
        press_btn(1);
        mode_exp.push_back(2);
        press_btn(2);
        check("press1_pulses_b", press_cnt[1], 3);
        check("press2_pulses", press_cnt[2], 1);

        // Both buttons debounce on the same edge: mode must hold.
        @(negedge clk);
        btn_n[2:1] = 2'b00;
        edges_until(2, 1, 30, n);
        check("both_lvl1", n, 6);
        check("both_lvl2", int'(btn_level[2]), 1);
        tick(3);
        check("both_mode_hold", int'(mode), 2);
        @(negedge clk);
        btn_n[2:1] = 2'b11;
        edges_until(2, 0, 30, n);
        tick(3);
        check("both_pulses1", press_cnt[1], 4);
        check("both_pulses2", press_cnt[2], 2);

        // Button 0 core reset while running.
        @(negedge clk);
        btn_n[0] = 1'b0;
        edges_until(0, 0, 30, n);
        check("btn0_assert_edges", n, 8);
        tick(10);
        check("btn0_held", int'(rst_core_n), 0);
        @(negedge clk);
        btn_n[0] = 1'b1;
        edges_until(0, 1, 40, n);
        check("btn0_release_edges", n, 16);
        check("mode_retained", int'(mode), 2);

        // Heartbeat: toggle every second vsync edge, watchdog stays quiet.
        ledr_min = 1;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            repeat (9) begin
                @(posedge clk);
                #1;
                if (!led_r_n) ledr_min = 0;
            end
            check($sformatf("led_g_pulse%0d", p), int'(led_g_n), (p == 1 || p == 2) ? 0 : 1);
        end
        check("led_r_with_vsync", ledr_min, 1);

        // Last edge reaches the counter 3 edges after the pin (2 sync + edge detect), then 20 cycles.
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vsync = 1'b0;
        edges_until(4, 0, 40, m);
        check("watchdog_trip_edges", 1 + m, 23);
        @(negedge clk);
        vsync = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vsync = 1'b0;
        edges_until(4, 1, 10, m);
        check("watchdog_recover_edges", 1 + m, 3);

        // Build up state, then hit rst_n mid-stretch and mid-debounce.
        mode_exp.push_back(1);
        @(negedge clk);
        btn_n[2] = 1'b0;
        edges_until(3, 1, 30, n);
        tick(2);
        @(negedge clk);
        btn_n[0] = 1'b0;
        edges_until(0, 0, 30, n);
        @(negedge clk);
        btn_n[0] = 1'b1;
        edges_until(1, 0, 30, n);
        tick(3);
        btn_n[1] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_in_stretch", int'(rst_core_n), 0);
        check("pre_rst_level2", int'(btn_level[2]), 1);
        check("pre_rst_mode", int'(mode), 1);
        check("scoreboard_drained", mode_exp.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");

        btn_n = '1;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
